// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the PC, issues credit-limited fetches to
// instruction memory and buffers in-order responses for decode, with redirect flush.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk1,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_ir,
  output logic [31:0] if_pc,
  output logic [31:0] if_npc,
  input  logic        id_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     resp_pc_q, resp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;

  logic [31:0]     ir_mem [DEPTH];
  logic [31:0]     pc_mem [DEPTH];

  logic            push, pop, accept, resp_ok;
  logic [CW:0]     inflight;
  logic [CW-1:0]   drop_base;
  logic [31:0]     redirect_aligned;

  assign redirect_aligned = redirect_pc & ~32'h3;
  assign inflight         = {1'b0, count_q} + {1'b0, outstanding_q};
  // Responses with nothing in flight are protocol errors and are dropped silently.
  assign resp_ok          = imem_rvalid && (outstanding_q != '0);
  assign drop_base        = (state_q == StFlush) ? drop_cnt_q : outstanding_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    head_d        = head_q;
    tail_d        = tail_q;
    imem_req      = 1'b0;
    accept        = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;

    if (redirect_valid) begin
      pc_d          = redirect_aligned;
      resp_pc_d     = redirect_aligned;
      count_d       = '0;
      head_d        = '0;
      tail_d        = '0;
      outstanding_d = '0;
      // Every request still in flight returns stale data that must be swallowed.
      drop_cnt_d    = drop_base - CW'(imem_rvalid && (drop_base != '0));
      state_d       = (drop_cnt_d != '0) ? StFlush : StRun;
    end else begin
      pop = (count_q != '0) && id_ready;
      unique case (state_q)
        StIdle: state_d = StRun;
        StRun: begin
          imem_req = inflight < DepthW;
          accept   = imem_req && imem_ready;
          push     = resp_ok;
        end
        StFlush: begin
          if (imem_rvalid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
          end
          if (drop_cnt_d == '0) begin
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase

      if (accept) begin
        pc_d = pc_q + 32'd4;
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        tail_d    = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      outstanding_d = outstanding_q + CW'(accept) - CW'(push);
      count_d       = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  // Storage is reset so the head entry presents the reset-time IR/PC values.
  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem[i] <= '0;
        pc_mem[i] <= RESET_PC;
      end
    end else if (push) begin
      ir_mem[tail_q] <= imem_rdata;
      pc_mem[tail_q] <= resp_pc_q;
    end
  end

  assign imem_addr = pc_q;
  assign if_valid  = count_q != '0;
  assign if_ir     = ir_mem[head_q];
  assign if_pc     = pc_mem[head_q];
  assign if_npc    = if_pc + 32'd4;

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a latency-configurable memory model feeds
// responses; expected {pc, ir} pairs are queued at accept and compared at pop.
module tb_ifetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 4;

  logic        clk1;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_pc;
  logic [31:0] if_npc;
  logic        id_ready;

  ifetch_queue #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk1           (clk1),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ir          (if_ir),
    .if_pc          (if_pc),
    .if_npc         (if_npc),
    .id_ready       (id_ready)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  exp_t        sb[$];
  req_t        mq[$];
  int          n_checks, n_errors;
  int          cycle, lat, accepts, pops;
  bit          rdy_rand, flushing, post_redir, hold_pend;
  logic [31:0] hold_addr, exp_pc;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check 1ns later, then advance.
  task automatic step(input logic redir, input logic [31:0] rpc, input logic spur);
    int          pre;
    logic        rv;
    logic [31:0] rd;
    exp_t        e;
    cycle++;
    pre = mq.size();
    rv  = 1'b0;
    rd  = '0;
    if (mq.size() > 0 && mq[0].due <= cycle) begin
      rv = 1'b1;
      rd = memword(mq[0].addr);
      void'(mq.pop_front());
    end else if (spur) begin
      rv = 1'b1;
      rd = 32'hDEAD_BEEF;
    end
    imem_rvalid    = rv;
    imem_rdata     = rd;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_ready     = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (post_redir) check_eq("valid_after_redirect", if_valid, 0);
    if (hold_pend && !redir) begin
      check_eq("req_held", imem_req, 1);
      check_eq("addr_held", imem_addr, hold_addr);
    end
    if (flushing && !redir) begin
      if (pre == 0) begin
        check_eq("req_after_flush", imem_req, 1);
        flushing = 1'b0;
      end else begin
        check_eq("req_in_flush", imem_req, 0);
      end
    end
    if (redir) begin
      check_eq("req_on_redirect", imem_req, 0);
      sb.delete();
      exp_pc     = rpc & ~32'h3;
      flushing   = 1'b1;
      post_redir = 1'b1;
    end else begin
      post_redir = 1'b0;
      if (if_valid && id_ready) begin
        pops++;
        if (sb.size() == 0) begin
          check_eq("pop_unexpected", if_valid, 0);
        end else begin
          e = sb.pop_front();
          check_eq("if_pc", if_pc, e.pc);
          check_eq("if_ir", if_ir, e.ir);
          check_eq("if_npc", if_npc, e.pc + 32'd4);
        end
      end
    end
    if (imem_req && imem_ready) begin
      check_eq("imem_addr", imem_addr, exp_pc);
      sb.push_back('{pc: exp_pc, ir: memword(exp_pc)});
      mq.push_back('{addr: imem_addr, due: cycle + lat});
      exp_pc = exp_pc + 32'd4;
      accepts++;
    end
    hold_pend = imem_req && !imem_ready;
    hold_addr = imem_addr;
    @(posedge clk1);
    @(negedge clk1);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    imem_ready     = 1'b0;
    @(posedge clk1);
    @(negedge clk1);
    rst = 1'b0;
    mq.delete();
    sb.delete();
    exp_pc     = RESET_PC;
    flushing   = 1'b0;
    post_redir = 1'b0;
    hold_pend  = 1'b0;
    #1;
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_addr", imem_addr, RESET_PC);
    check_eq("rst_valid", if_valid, 0);
    check_eq("rst_ir", if_ir, 0);
    check_eq("rst_pc", if_pc, RESET_PC);
    check_eq("rst_npc", if_npc, RESET_PC + 32'd4);
  endtask

  initial begin
    int wp;
    n_checks = 0;
    n_errors = 0;
    cycle    = 0;
    rdy_rand = 1'b0;
    id_ready = 1'b1;
    lat      = 1;

    // Streaming with 1-cycle memory; spurious rvalid right after reset must be ignored.
    do_reset();
    accepts = 0;
    pops    = 0;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    repeat (18) step(1'b0, '0, 1'b0);
    check_eq("t1_accepts", accepts, 19);
    check_eq("t1_pops", pops, 17);

    // Decode stalled: credits cap accepts at DEPTH, then drain.
    id_ready = 1'b0;
    do_reset();
    accepts = 0;
    repeat (10) step(1'b0, '0, 1'b0);
    check_eq("t2_accepts", accepts, DEPTH);
    check_eq("t2_req_off", imem_req, 0);
    check_eq("t2_valid", if_valid, 1);
    id_ready = 1'b1;
    pops     = 0;
    repeat (4) step(1'b0, '0, 1'b0);
    check_eq("t2_pops", pops, 4);
    repeat (8) step(1'b0, '0, 1'b0);

    // Randomly stalling memory and decode.
    lat      = 2;
    rdy_rand = 1'b1;
    repeat (60) begin
      id_ready = 1'($urandom_range(0, 1));
      step(1'b0, '0, 1'b0);
    end
    rdy_rand = 1'b0;
    id_ready = 1'b1;
    repeat (10) step(1'b0, '0, 1'b0);

    // Redirect with several requests in flight on a 3-cycle memory.
    lat = 3;
    for (int i = 0; i < 20; i++) begin
      if (mq.size() >= 3) break;
      step(1'b0, '0, 1'b0);
    end
    step(1'b1, 32'h0000_0102, 1'b0);
    pops = 0;
    repeat (20) step(1'b0, '0, 1'b0);
    check_eq("t4_resumed", pops != 0, 1);
    check_eq("t4_flush_done", flushing, 0);

    // Redirect coinciding with an rvalid and a pop.
    lat = 1;
    repeat (8) step(1'b0, '0, 1'b0);
    step(1'b1, 32'h0000_0040, 1'b0);
    repeat (10) step(1'b0, '0, 1'b0);

    // Second redirect while still flushing.
    lat = 3;
    for (int i = 0; i < 20; i++) begin
      if (mq.size() >= 3) break;
      step(1'b0, '0, 1'b0);
    end
    step(1'b1, 32'h0000_0180, 1'b0);
    for (int i = 0; i < 10; i++) begin
      wp = (mq.size() > 0 && mq[0].due <= cycle + 1) ? 1 : 0;
      if (mq.size() - wp == 2) break;
      step(1'b0, '0, 1'b0);
    end
    step(1'b1, 32'h0000_0200, 1'b0);
    pops = 0;
    repeat (20) step(1'b0, '0, 1'b0);
    check_eq("t6_resumed", pops != 0, 1);
    check_eq("t6_flush_done", flushing, 0);

    // Reset in the middle of streaming.
    lat = 1;
    repeat (6) step(1'b0, '0, 1'b0);
    do_reset();
    repeat (6) step(1'b0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
